// File: rtl/memoria_instrucoes_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : memoria_instrucoes_param                                     |
// | Description : Parametrised instruction RAM with boot-fill init FSM and a   |
// |               req/valid access pipeline of 1 or 2 cycles.                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module memoria_instrucoes_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 1,
  parameter int BOOT_EN  = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wren,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Q,
  output logic              Valid,
  output logic              Busy,
  output logic              Err
);

  localparam logic [0:0]        ST_INIT    = 1'b0;
  localparam logic [0:0]        ST_READY   = 1'b1;
  localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;

  logic              w_acc;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rsp_q;

  function automatic logic [DATA_W-1:0] f_init_word(input logic [ADDR_W-1:0] idx);
    logic [15:0] boot_word;
    case (32'(idx))
      0:       boot_word = 16'h8882;
      1:       boot_word = 16'hA081;
      2:       boot_word = 16'h40A0;
      3:       boot_word = 16'h6512;
      4:       boot_word = 16'h6090;
      5:       boot_word = 16'h4020;
      6:       boot_word = 16'h40A0;
      default: boot_word = 16'h0000;
    endcase
    if (BOOT_EN == 0) boot_word = 16'h0000;
    return DATA_W'(boot_word);
  endfunction

  assign Busy       = (r_state == ST_INIT);
  assign w_acc      = (r_state == ST_READY) && Req;
  assign w_in_range = (32'(Address) < 32'(DEPTH));
  // Out-of-range responses return zero, for writes as well as reads.
  assign w_rsp_q    = !w_in_range ? '0 : (Wren ? Din : r_mem[Address]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_ptr == C_LAST_PTR) r_state <= ST_READY;
      r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (r_state == ST_INIT)
        r_mem[r_ptr] <= f_init_word(r_ptr);
      else if (w_acc && Wren && w_in_range)
        r_mem[Address] <= Din;
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge Clock) begin
        if (Reset) begin
          Q     <= '0;
          Valid <= 1'b0;
          Err   <= 1'b0;
        end else begin
          Valid <= w_acc;
          Err   <= w_acc && !w_in_range;
          if (w_acc) Q <= w_rsp_q;
        end
      end
    end else begin : g_lat2
      logic              r_s_v;
      logic              r_s_e;
      logic [DATA_W-1:0] r_s_q;
      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_s_v <= 1'b0;
          r_s_e <= 1'b0;
          r_s_q <= '0;
          Q     <= '0;
          Valid <= 1'b0;
          Err   <= 1'b0;
        end else begin
          r_s_v <= w_acc;
          r_s_e <= w_acc && !w_in_range;
          r_s_q <= w_rsp_q;
          Valid <= r_s_v;
          Err   <= r_s_e;
          if (r_s_v) Q <= r_s_q;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_memoria_instrucoes_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_memoria_instrucoes_param                                  |
// | Description : Four configurations driven in lock-step against a model.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_memoria_instrucoes_param;

  logic        Clock = 1'b0;
  logic        Reset, req, wren;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [15:0] q0, q1, q2;
  logic [31:0] q3;
  logic [3:0]  va, ea, ba;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int busy_run = 0;

  logic [31:0] mdl_mem [4][16];
  int          busy_left [4];
  logic [31:0] exp_q [4];
  logic        sch_v [4][4];
  logic        sch_e [4][4];
  logic [31:0] sch_q [4][4];

  always #5 Clock = ~Clock;

  // 0: defaults, 1: READ_LAT=2, 2: DEPTH=12, 3: BOOT_EN=0 with 32-bit words
  memoria_instrucoes_param u_def (.Clock(Clock), .Reset(Reset), .Req(req), .Wren(wren),
    .Address(addr), .Din(din[15:0]), .Q(q0), .Valid(va[0]), .Busy(ba[0]), .Err(ea[0]));
  memoria_instrucoes_param #(.READ_LAT(2)) u_lat2 (.Clock(Clock), .Reset(Reset), .Req(req),
    .Wren(wren), .Address(addr), .Din(din[15:0]), .Q(q1), .Valid(va[1]), .Busy(ba[1]), .Err(ea[1]));
  memoria_instrucoes_param #(.DEPTH(12)) u_d12 (.Clock(Clock), .Reset(Reset), .Req(req),
    .Wren(wren), .Address(addr), .Din(din[15:0]), .Q(q2), .Valid(va[2]), .Busy(ba[2]), .Err(ea[2]));
  memoria_instrucoes_param #(.DATA_W(32), .BOOT_EN(0)) u_nb (.Clock(Clock), .Reset(Reset),
    .Req(req), .Wren(wren), .Address(addr), .Din(din), .Q(q3), .Valid(va[3]), .Busy(ba[3]), .Err(ea[3]));

  function automatic int depth_of(int i); return (i == 2) ? 12 : 16; endfunction
  function automatic int lat_of(int i);   return (i == 1) ? 2 : 1;   endfunction
  function automatic logic [31:0] mask_of(int i);
    return (i == 3) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction
  function automatic logic [31:0] boot_of(int i, int a);
    logic [15:0] tbl [7];
    tbl = '{16'h8882, 16'hA081, 16'h40A0, 16'h6512, 16'h6090, 16'h4020, 16'h40A0};
    if (i == 3 || a >= depth_of(i) || a > 6) return 32'h0;
    return {16'h0, tbl[a]};
  endfunction
  function automatic logic [31:0] q_of(int i);
    case (i)
      0: return {16'h0, q0};
      1: return {16'h0, q1};
      2: return {16'h0, q2};
      default: return q3;
    endcase
  endfunction

  task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s[inst%0d] edge %0d: observed %h expected %h", tag, i, edge_n, got, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic r, input logic w,
                     input logic [3:0] a, input logic [31:0] d);
    Reset = rst; req = r; wren = w; addr = a; din = d;
    @(posedge Clock);
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        for (int s = 0; s < 4; s++) begin sch_v[i][s] = 1'b0; sch_e[i][s] = 1'b0; end
        exp_q[i] = 32'h0;
        busy_left[i] = depth_of(i);
        for (int j = 0; j < 16; j++) mdl_mem[i][j] = boot_of(i, j);
      end else if (busy_left[i] > 0) begin
        busy_left[i]--;
      end else if (r) begin
        int slot;
        logic in_rng;
        logic [31:0] rq;
        in_rng = (int'(a) < depth_of(i));
        rq = !in_rng ? 32'h0 : (w ? (d & mask_of(i)) : mdl_mem[i][a]);
        if (in_rng && w) mdl_mem[i][a] = d & mask_of(i);
        slot = (edge_n + lat_of(i) - 1) % 4;
        sch_v[i][slot] = 1'b1;
        sch_e[i][slot] = !in_rng;
        sch_q[i][slot] = rq;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = edge_n % 4;
      if (sch_v[i][k]) exp_q[i] = sch_q[i][k];
      check("valid", i, {31'h0, va[i]}, {31'h0, sch_v[i][k]});
      check("err",   i, {31'h0, ea[i]}, {31'h0, sch_v[i][k] & sch_e[i][k]});
      check("busy",  i, {31'h0, ba[i]}, {31'h0, busy_left[i] > 0});
      check("q",     i, q_of(i), exp_q[i]);
      sch_v[i][k] = 1'b0;
      sch_e[i][k] = 1'b0;
    end
    if (rst) busy_run = 0;
    if (ba[0]) busy_run++;
    edge_n++;
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1; req = 1'b0; wren = 1'b0; addr = 4'h0; din = 32'h0;
    @(negedge Clock);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    // Requests during INIT must be ignored, writes included.
    for (int n = 0; n < 20; n++) cyc(1'b0, 1'b1, n[0], 4'(n), 32'hDEAD_0000 + n);
    check("busy_len", 0, busy_run, 16);
    for (int n = 0; n < 8; n++) cyc(1'b0, 1'b1, 1'b0, 4'(n), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 4'd9, 32'h0000_1234);
    cyc(1'b0, 1'b1, 1'b0, 4'd9, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_BEEF);
    cyc(1'b0, 1'b1, 1'b0, 4'd13, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    for (int n = 0; n < 3; n++) cyc(1'b0, 1'b1, 1'b0, 4'(n), 32'h0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          4'($urandom_range(0, 15)), $urandom);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    // Reset while a read is in flight: its response must never surface.
    cyc(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 4'd4, 32'h0);
    for (int n = 0; n < 20; n++) cyc(1'b0, 1'b1, 1'b0, 4'(n), 32'h0);
    check("busy_len2", 0, busy_run, 16);
    for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 1'b0, 4'(n), 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
